mcp3008_scanner: RTL and testbench

MCP3008_SCANNER -- requirements
Module: mcp3008_scanner

---
 rtl/mcp3008_scanner_if.sv | 10 +
 rtl/mcp3008_scanner.sv | 204 ++++++++++++++++++++
 tb/tb_mcp3008_scanner.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp3008_scanner_if.sv
// Byte stream from the scanner toward the FT245 transmit path.
// A byte moves when tx_valid and tx_ready are both high on a rising clock edge.
interface mcp3008_scanner_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/mcp3008_scanner.sv
// MCP3008 channel scanner: runs 17-clock SPI conversions per channel, optionally averages,
// and streams each averaged sample as a {chan, 000, b9:b8} / b7:b0 byte pair.
module mcp3008_scanner #(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned N_CHAN   = 8,
  parameter int unsigned AVG_LOG2 = 0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  output logic              busy,
  output logic              mcp_cs_n,
  output logic              mcp_dclk,
  output logic              mcp_din,
  input  logic              mcp_dout,
  mcp3008_scanner_if.master tx
);

  localparam int unsigned AccW     = 10 + AVG_LOG2;
  localparam logic [8:0]  DivLast  = 9'(CLK_DIV - 1);
  localparam logic [8:0]  GapLast  = 9'(2 * CLK_DIV - 1);
  localparam logic [4:0]  ConvLast = 5'((1 << AVG_LOG2) - 1);
  localparam logic [2:0]  ChanLast = 3'(N_CHAN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsGap,
    StEmitHi,
    StEmitLo
  } state_e;

  state_e          state_q, state_d;
  logic [8:0]      div_q, div_d;
  logic [4:0]      edge_q, edge_d;
  logic            dclk_q, dclk_d;
  logic            din_q, din_d;
  logic [2:0]      chan_q, chan_d;
  logic [4:0]      conv_q, conv_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [9:0]      shreg_q, shreg_d;
  logic [9:0]      sample_q, sample_d;

  logic            div_last;
  logic            next_din;
  logic [AccW-1:0] acc_sum;
  logic [AccW-1:0] acc_avg;

  assign div_last = (div_q == DivLast);
  assign acc_sum  = acc_q + AccW'(shreg_q);
  assign acc_avg  = acc_sum >> AVG_LOG2;

  // edge_q counts completed rising edges; this is the command bit for the following edge
  always_comb begin
    next_din = 1'b0;
    case (edge_q)
      5'd1:    next_din = 1'b1;
      5'd2:    next_din = chan_q[2];
      5'd3:    next_din = chan_q[1];
      5'd4:    next_din = chan_q[0];
      default: next_din = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      edge_q   <= '0;
      dclk_q   <= 1'b0;
      din_q    <= 1'b0;
      chan_q   <= '0;
      conv_q   <= '0;
      acc_q    <= '0;
      shreg_q  <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      edge_q   <= edge_d;
      dclk_q   <= dclk_d;
      din_q    <= din_d;
      chan_q   <= chan_d;
      conv_q   <= conv_d;
      acc_q    <= acc_d;
      shreg_q  <= shreg_d;
      sample_q <= sample_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    edge_d   = edge_q;
    dclk_d   = dclk_q;
    din_d    = din_q;
    chan_d   = chan_q;
    conv_d   = conv_q;
    acc_d    = acc_q;
    shreg_d  = shreg_q;
    sample_d = sample_q;
    unique case (state_q)
      StIdle: begin
        if (start || cont) begin
          state_d = StCsSetup;
          div_d   = '0;
          chan_d  = '0;
          conv_d  = '0;
          acc_d   = '0;
        end
      end
      StCsSetup: begin
        if (div_last) begin
          state_d = StShift;
          div_d   = '0;
          edge_d  = '0;
          din_d   = 1'b1;
        end else begin
          div_d = div_q + 9'd1;
        end
      end
      StShift: begin
        if (!div_last) begin
          div_d = div_q + 9'd1;
        end else begin
          div_d = '0;
          if (!dclk_q) begin
            dclk_d = 1'b1;
            edge_d = edge_q + 5'd1;
            // rising edges 8..17 carry B9..B0
            if (edge_q >= 5'd7) shreg_d = {shreg_q[8:0], mcp_dout};
          end else begin
            dclk_d = 1'b0;
            if (edge_q == 5'd17) begin
              state_d = StCsGap;
              din_d   = 1'b0;
            end else begin
              din_d = next_din;
            end
          end
        end
      end
      StCsGap: begin
        if (div_q != GapLast) begin
          div_d = div_q + 9'd1;
        end else begin
          div_d  = '0;
          conv_d = conv_q + 5'd1;
          if (conv_q == ConvLast) begin
            sample_d = acc_avg[9:0];
            state_d  = StEmitHi;
          end else begin
            acc_d   = acc_sum;
            state_d = StCsSetup;
          end
        end
      end
      StEmitHi: begin
        if (tx.tx_ready) state_d = StEmitLo;
      end
      StEmitLo: begin
        if (tx.tx_ready) begin
          conv_d = '0;
          acc_d  = '0;
          if (chan_q != ChanLast) begin
            chan_d  = chan_q + 3'd1;
            state_d = StCsSetup;
          end else if (cont) begin
            chan_d  = '0;
            state_d = StCsSetup;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mcp_cs_n    = 1'b1;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    busy        = (state_q != StIdle);
    unique case (state_q)
      StCsSetup, StShift: mcp_cs_n = 1'b0;
      StEmitHi: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = {chan_q, 3'b000, sample_q[9:8]};
      end
      StEmitLo: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = sample_q[7:0];
      end
      default: ;
    endcase
  end

  assign mcp_dclk = dclk_q;
  assign mcp_din  = din_q;

endmodule

// File: tb/tb_mcp3008_scanner.sv
// Bench for mcp3008_scanner: dut0 uses default parameters, dut1 uses CLK_DIV=4, N_CHAN=1,
// AVG_LOG2=2. Bytes are checked by per-DUT scoreboards fed from directed stimulus.
module tb_mcp3008_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, cont0 = 1'b0, start1 = 1'b0, cont1 = 1'b0;
  logic busy0, cs_n0, dclk0, din0, busy1, cs_n1, dclk1, din1;
  logic dout0 = 1'b0, dout1 = 1'b0;
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcp3008_scanner_if tx0 ();
  mcp3008_scanner_if tx1 ();

  mcp3008_scanner dut0 (
    .clk_in  (clk),
    .rst     (rst),
    .start   (start0),
    .cont    (cont0),
    .busy    (busy0),
    .mcp_cs_n(cs_n0),
    .mcp_dclk(dclk0),
    .mcp_din (din0),
    .mcp_dout(dout0),
    .tx      (tx0.master)
  );

  mcp3008_scanner #(.CLK_DIV(4), .N_CHAN(1), .AVG_LOG2(2)) dut1 (
    .clk_in  (clk),
    .rst     (rst),
    .start   (start1),
    .cont    (cont1),
    .busy    (busy1),
    .mcp_cs_n(cs_n1),
    .mcp_dclk(dclk1),
    .mcp_din (din1),
    .mcp_dout(dout1),
    .tx      (tx1.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- ADC model, dut0: 10'h2A5 on channel 3, 10'h100 elsewhere
  int          e0 = 0;
  logic [16:0] cmd0 = '0;
  logic [9:0]  val0 = 10'h100;
  logic        pcs0 = 1'b1, pdclk0 = 1'b0, pdin0 = 1'b0;
  int          pin_viol0 = 0;

  always @(negedge clk) begin
    if (pcs0 && !cs_n0) begin
      e0   = 0;
      cmd0 = '0;
    end
    if (!cs_n0 && !pdclk0 && dclk0) begin
      e0++;
      cmd0 = {cmd0[15:0], din0};
      if (e0 == 5) val0 = (cmd0[2:0] == 3'd3) ? 10'h2A5 : 10'h100;
    end
    if (!pcs0 && cs_n0 && e0 == 17)
      check("dut0 command bits", 32'({cmd0[16:15], cmd0[11:0]}), 32'({2'b11, 12'h000}));
    if (dclk0 && din0 != pdin0) pin_viol0++;
    if (cs_n0 && dclk0) pin_viol0++;
    dout0  = (!cs_n0 && e0 >= 7 && e0 <= 16) ? val0[16-e0] : 1'b0;
    pcs0   = cs_n0;
    pdclk0 = dclk0;
    pdin0  = din0;
  end

  // ---------------- ADC model, dut1: fixed conversion sequence, timing checks
  logic [9:0]  seq1 [4] = '{10'h3FF, 10'h3FF, 10'h001, 10'h002};
  int          e1 = 0, conv1 = 0, hi1 = 0, gap1 = 0, pin_viol1 = 0;
  logic [16:0] cmd1 = '0;
  logic [9:0]  val1 = '0;
  logic        pcs1 = 1'b1, pdclk1 = 1'b0, pdin1 = 1'b0;

  always @(negedge clk) begin
    if (pcs1 && !cs_n1) begin
      e1   = 0;
      cmd1 = '0;
      val1 = seq1[conv1 % 4];
      conv1++;
      if (gap1 != 0) check("dut1 cs_n gap >= 8", 32'(gap1 >= 8), 32'd1);
      gap1 = 0;
    end
    if (!cs_n1 && !pdclk1 && dclk1) begin
      e1++;
      cmd1 = {cmd1[15:0], din1};
    end
    if (dclk1) hi1++;
    if (pdclk1 && !dclk1) begin
      check("dut1 dclk high width", 32'(hi1), 32'd4);
      hi1 = 0;
    end
    if (!pcs1 && cs_n1) begin
      check("dut1 dclk edges", 32'(e1), 32'd17);
      check("dut1 command bits", 32'(cmd1), 32'h18000);
    end
    if (cs_n1 && busy1) gap1++;
    if (!busy1) gap1 = 0;
    if (dclk1 && din1 != pdin1) pin_viol1++;
    if (cs_n1 && dclk1) pin_viol1++;
    dout1  = (!cs_n1 && e1 >= 7 && e1 <= 16) ? val1[16-e1] : 1'b0;
    pcs1   = cs_n1;
    pdclk1 = dclk1;
    pdin1  = din1;
  end

  // ---------------- scoreboards and monitors
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int hs0 = 0, hs1 = 0, last_hs0 = 0, valid_viol = 0;

  always @(negedge clk) begin
    if ((tx0.tx_valid && !cs_n0) || (tx1.tx_valid && !cs_n1)) valid_viol++;
    if (tx0.tx_valid && tx0.tx_ready) begin
      hs0++;
      last_hs0 = cyc;
      if (exp0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut0 unexpected byte: got %02h, required none", tx0.tx_data);
      end else begin
        check("dut0 byte", 32'(tx0.tx_data), 32'(exp0.pop_front()));
      end
    end
    if (tx1.tx_valid && tx1.tx_ready) begin
      hs1++;
      if (exp1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected byte: got %02h, required none", tx1.tx_data);
      end else begin
        check("dut1 byte", 32'(tx1.tx_data), 32'(exp1.pop_front()));
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic push_pass0();
    logic [9:0] v;
    for (int ch = 0; ch < 8; ch++) begin
      v = (ch == 3) ? 10'h2A5 : 10'h100;
      exp0.push_back({3'(ch), 3'b000, v[9:8]});
      exp0.push_back(v[7:0]);
    end
  endtask

  task automatic pulse_start0();
    @(posedge clk) #1 start0 = 1'b1;
    @(posedge clk) #1 start0 = 1'b0;
  endtask

  task automatic wait_idle0(input string name, input int budget, output int idle_cyc);
    int n;
    n = 0;
    idle_cyc = -1;
    while (busy0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy0) check({name, " timeout"}, 32'(busy0), 32'd0);
    else idle_cyc = cyc;
  endtask

  initial begin
    int idle_cyc, base, n, viol;
    logic [7:0] held;
    tx0.tx_ready = 1'b1;
    tx1.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset cs_n", 32'(cs_n0), 32'd1);
    check("reset dclk", 32'(dclk0), 32'd0);
    check("reset din", 32'(din0), 32'd0);
    check("reset tx_valid", 32'(tx0.tx_valid), 32'd0);
    check("reset tx_data", 32'(tx0.tx_data), 32'd0);
    check("reset dut1 cs_n", 32'(cs_n1), 32'd1);
    @(posedge clk) #1 rst = 1'b0;

    // dut1: four conversions averaged on channel 0
    exp1.push_back(8'h02);
    exp1.push_back(8'h00);
    @(posedge clk) #1 start1 = 1'b1;
    @(posedge clk) #1 start1 = 1'b0;
    n = 0;
    while (busy1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("dut1 idle after pass", 32'(busy1), 32'd0);
    check("dut1 byte count", 32'(hs1), 32'd2);
    check("dut1 conversions", 32'(conv1), 32'd4);
    check("dut1 pin violations", 32'(pin_viol1), 32'd0);

    // dut0: single pass, with a start while busy that must be ignored
    push_pass0();
    base = hs0;
    pulse_start0();
    repeat (1000) @(posedge clk);
    pulse_start0();
    wait_idle0("pass1", 6000, idle_cyc);
    check("pass1 byte count", 32'(hs0 - base), 32'd16);
    check("pass1 busy falls with byte 16", 32'(idle_cyc), 32'(last_hs0 + 1));
    repeat (20) @(negedge clk);
    check("pass1 stays idle", 32'(busy0), 32'd0);

    // stall on the first EMIT_HI byte
    push_pass0();
    base = hs0;
    @(posedge clk) #1 tx0.tx_ready = 1'b0;
    pulse_start0();
    n = 0;
    while (!tx0.tx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("stall tx_valid seen", 32'(tx0.tx_valid), 32'd1);
    held = tx0.tx_data;
    check("stall held byte", 32'(held), 32'h01);
    viol = 0;
    repeat (500) begin
      @(negedge clk);
      if (!tx0.tx_valid || tx0.tx_data != held || !cs_n0) viol++;
    end
    check("stall stability violations", 32'(viol), 32'd0);
    @(posedge clk) #1 tx0.tx_ready = 1'b1;
    wait_idle0("stall pass", 6000, idle_cyc);
    check("stall pass byte count", 32'(hs0 - base), 32'd16);

    // continuous mode: two full passes, cont dropped during the third
    push_pass0();
    push_pass0();
    push_pass0();
    base = hs0;
    @(posedge clk) #1 cont0 = 1'b1;
    n = 0;
    while (hs0 < base + 36 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    check("cont reached third pass", 32'(hs0 >= base + 36), 32'd1);
    @(posedge clk) #1 cont0 = 1'b0;
    wait_idle0("cont", 6000, idle_cyc);
    check("cont byte count", 32'(hs0 - base), 32'd48);
    check("cont scoreboard drained", 32'(exp0.size()), 32'd0);

    // reset at dclk edge 10, with start asserted in the same cycle
    base = hs0;
    pulse_start0();
    n = 0;
    while (e0 != 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached dclk edge 10", 32'(e0), 32'd10);
    @(posedge clk) #1;
    rst    = 1'b1;
    start0 = 1'b1;
    @(posedge clk) #1;
    rst    = 1'b0;
    start0 = 1'b0;
    @(negedge clk);
    check("abort cs_n", 32'(cs_n0), 32'd1);
    check("abort tx_valid", 32'(tx0.tx_valid), 32'd0);
    check("abort dclk", 32'(dclk0), 32'd0);
    repeat (50) @(negedge clk);
    check("abort stays idle", 32'(busy0), 32'd0);
    check("abort no bytes", 32'(hs0 - base), 32'd0);

    push_pass0();
    base = hs0;
    pulse_start0();
    wait_idle0("post-reset pass", 6000, idle_cyc);
    check("post-reset byte count", 32'(hs0 - base), 32'd16);
    check("dut0 scoreboard drained", 32'(exp0.size()), 32'd0);
    check("dut0 pin violations", 32'(pin_viol0), 32'd0);
    check("tx_valid outside emit", 32'(valid_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
